// File: rtl/atm_pkg.sv
// Shared definitions for the ATM account server and the ATM front-end.
// Holds the request op codes, response status codes, the server FSM state
// type and the default configuration constants.
package atm_pkg;

    typedef enum logic [2:0] {
        OP_DEPOSIT  = 3'd0,
        OP_WITHDRAW = 3'd1,
        OP_BALANCE  = 3'd2,
        OP_TRANSFER = 3'd3,
        OP_EXIT     = 3'd4,
        OP_AUTH     = 3'd5
    } op_t;

    typedef enum logic [2:0] {
        ST_OK           = 3'd0,
        ST_BAD_PIN      = 3'd1,
        ST_LOCKED       = 3'd2,
        ST_INSUFFICIENT = 3'd3,
        ST_OVERFLOW     = 3'd4,
        ST_NOT_AUTH     = 3'd5,
        ST_BAD_OP       = 3'd6
    } status_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          ATM_NUM_ACCTS    = 4;
    localparam int          ATM_ACCT_W       = 2;
    localparam logic [7:0]  ATM_INIT_BALANCE = 8'd100;
    localparam logic [15:0] ATM_PIN_BASE     = 16'h1234;
    localparam int          ATM_MAX_TRIES    = 3;

endpackage

// File: rtl/atm_acct_alu.sv
// Combinational evaluation of one latched request against the current
// account state.
//   op/acct/dst/pin/amount : latched request fields
//   sess_valid/sess_acct   : current session
//   src_bal/dst_bal        : balances of session account / destination
//   acct_locked/acct_fails : lock flag and fail count of the AUTH account
//   status                 : response status code
//   src_we/src_new         : session-account balance write
//   dst_we/dst_new         : destination balance write (TRANSFER)
//   sess_set/sess_clr      : session open (to acct) / close
//   fail_inc/fail_clr/lock_set : PIN-failure bookkeeping for acct
module atm_acct_alu
    import atm_pkg::*;
#(
    parameter int          ACCT_W    = ATM_ACCT_W,
    parameter logic [15:0] PIN_BASE  = ATM_PIN_BASE,
    parameter int          MAX_TRIES = ATM_MAX_TRIES,
    parameter int          FAIL_W    = 2
) (
    input  logic [2:0]        op,
    input  logic [ACCT_W-1:0] acct,
    input  logic [ACCT_W-1:0] dst,
    input  logic [15:0]       pin,
    input  logic [7:0]        amount,
    input  logic              sess_valid,
    input  logic [ACCT_W-1:0] sess_acct,
    input  logic [7:0]        src_bal,
    input  logic [7:0]        dst_bal,
    input  logic              acct_locked,
    input  logic [FAIL_W-1:0] acct_fails,
    output logic [2:0]        status,
    output logic              src_we,
    output logic [7:0]        src_new,
    output logic              dst_we,
    output logic [7:0]        dst_new,
    output logic              sess_set,
    output logic              sess_clr,
    output logic              fail_inc,
    output logic              fail_clr,
    output logic              lock_set
);

    logic [8:0] src_sum;
    logic [8:0] dst_sum;

    assign src_sum = {1'b0, src_bal} + {1'b0, amount};
    assign dst_sum = {1'b0, dst_bal} + {1'b0, amount};

    always_comb begin
        status   = ST_OK;
        src_we   = 1'b0;
        src_new  = src_bal;
        dst_we   = 1'b0;
        dst_new  = dst_bal;
        sess_set = 1'b0;
        sess_clr = 1'b0;
        fail_inc = 1'b0;
        fail_clr = 1'b0;
        lock_set = 1'b0;
        case (op)
            OP_AUTH: begin
                if (acct_locked) begin
                    status = ST_LOCKED;
                end else if (pin == (PIN_BASE ^ 16'(acct))) begin
                    sess_set = 1'b1;
                    fail_clr = 1'b1;
                end else begin
                    status   = ST_BAD_PIN;
                    fail_inc = 1'b1;
                    sess_clr = 1'b1;
                    lock_set = (int'(acct_fails) + 1 >= MAX_TRIES);
                end
            end
            OP_EXIT: sess_clr = 1'b1;
            OP_DEPOSIT, OP_WITHDRAW, OP_BALANCE, OP_TRANSFER: begin
                if (!sess_valid) begin
                    status = ST_NOT_AUTH;
                end else begin
                    case (op)
                        OP_DEPOSIT: begin
                            if (src_sum[8]) begin
                                status = ST_OVERFLOW;
                            end else begin
                                src_we  = 1'b1;
                                src_new = src_sum[7:0];
                            end
                        end
                        OP_WITHDRAW: begin
                            if (amount > src_bal) begin
                                status = ST_INSUFFICIENT;
                            end else begin
                                src_we  = 1'b1;
                                src_new = src_bal - amount;
                            end
                        end
                        OP_TRANSFER: begin
                            // Self-transfer is a no-op; writing both ports to
                            // the same entry would lose one of the updates.
                            if (amount > src_bal) begin
                                status = ST_INSUFFICIENT;
                            end else if (dst != sess_acct) begin
                                if (dst_sum[8]) begin
                                    status = ST_OVERFLOW;
                                end else begin
                                    src_we  = 1'b1;
                                    src_new = src_bal - amount;
                                    dst_we  = 1'b1;
                                    dst_new = dst_sum[7:0];
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: status = ST_BAD_OP;
        endcase
    end

endmodule

// File: rtl/atm_account_server.sv
// Bank-side responder for ATM transaction requests. Holds the balance
// table, PIN-failure counters, lock flags and the single active session.
//   clk, rst                 : clock, async active-high reset
//   req_valid/req_ready      : request handshake (accepted only in IDLE)
//   req_op/acct/dst_acct/pin/amount : request fields, latched on accept
//   rsp_valid/rsp_ready      : response handshake
//   rsp_status/rsp_balance   : result code and session post-op balance
module atm_account_server
    import atm_pkg::*;
#(
    parameter int          NUM_ACCTS    = ATM_NUM_ACCTS,
    parameter int          ACCT_W       = ATM_ACCT_W,
    parameter logic [7:0]  INIT_BALANCE = ATM_INIT_BALANCE,
    parameter logic [15:0] PIN_BASE     = ATM_PIN_BASE,
    parameter int          MAX_TRIES    = ATM_MAX_TRIES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ACCT_W-1:0] req_acct,
    input  logic [ACCT_W-1:0] req_dst_acct,
    input  logic [15:0]       req_pin,
    input  logic [7:0]        req_amount,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2:0]        rsp_status,
    output logic [7:0]        rsp_balance
);

    localparam int FAIL_W = $clog2(MAX_TRIES + 1);

    state_t state, state_next;

    logic [7:0]        bal   [NUM_ACCTS];
    logic [FAIL_W-1:0] fails [NUM_ACCTS];
    logic [NUM_ACCTS-1:0] locked;
    logic              sess_valid;
    logic [ACCT_W-1:0] sess_acct;

    logic [2:0]        lat_op;
    logic [ACCT_W-1:0] lat_acct;
    logic [ACCT_W-1:0] lat_dst;
    logic [15:0]       lat_pin;
    logic [7:0]        lat_amount;

    logic [2:0] alu_status;
    logic       src_we, dst_we;
    logic [7:0] src_new, dst_new;
    logic       sess_set, sess_clr, fail_inc, fail_clr, lock_set;
    logic [7:0] rsp_balance_next;

    atm_acct_alu #(
        .ACCT_W    (ACCT_W),
        .PIN_BASE  (PIN_BASE),
        .MAX_TRIES (MAX_TRIES),
        .FAIL_W    (FAIL_W)
    ) u_alu (
        .op          (lat_op),
        .acct        (lat_acct),
        .dst         (lat_dst),
        .pin         (lat_pin),
        .amount      (lat_amount),
        .sess_valid  (sess_valid),
        .sess_acct   (sess_acct),
        .src_bal     (bal[sess_acct]),
        .dst_bal     (bal[lat_dst]),
        .acct_locked (locked[lat_acct]),
        .acct_fails  (fails[lat_acct]),
        .status      (alu_status),
        .src_we      (src_we),
        .src_new     (src_new),
        .dst_we      (dst_we),
        .dst_new     (dst_new),
        .sess_set    (sess_set),
        .sess_clr    (sess_clr),
        .fail_inc    (fail_inc),
        .fail_clr    (fail_clr),
        .lock_set    (lock_set)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // req_ready is gated by rst so it reads 0 while reset is held.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ~rst;
                if (req_valid) state_next = EXEC;
            end
            EXEC: state_next = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Balance reported is the session's after this op, whichever session
    // survives it.
    always_comb begin
        rsp_balance_next = '0;
        if (sess_set)
            rsp_balance_next = bal[lat_acct];
        else if (!sess_clr && sess_valid)
            rsp_balance_next = src_we ? src_new : bal[sess_acct];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ACCTS; i++) begin
                bal[i]   <= INIT_BALANCE;
                fails[i] <= '0;
            end
            locked      <= '0;
            sess_valid  <= 1'b0;
            sess_acct   <= '0;
            lat_op      <= '0;
            lat_acct    <= '0;
            lat_dst     <= '0;
            lat_pin     <= '0;
            lat_amount  <= '0;
            rsp_status  <= '0;
            rsp_balance <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_op     <= req_op;
                lat_acct   <= req_acct;
                lat_dst    <= req_dst_acct;
                lat_pin    <= req_pin;
                lat_amount <= req_amount;
            end
            if (state == EXEC) begin
                if (src_we)   bal[sess_acct]  <= src_new;
                if (dst_we)   bal[lat_dst]    <= dst_new;
                if (fail_clr) fails[lat_acct] <= '0;
                if (fail_inc) fails[lat_acct] <= fails[lat_acct] + 1'b1;
                if (lock_set) locked[lat_acct] <= 1'b1;
                if (sess_set) begin
                    sess_valid <= 1'b1;
                    sess_acct  <= lat_acct;
                end else if (sess_clr) begin
                    sess_valid <= 1'b0;
                end
                rsp_status  <= alu_status;
                rsp_balance <= rsp_balance_next;
            end
        end
    end

endmodule

// File: tb/tb_atm_account_server.sv
module tb_atm_account_server;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [1:0]  req_acct;
    logic [1:0]  req_dst_acct;
    logic [15:0] req_pin;
    logic [7:0]  req_amount;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_status;
    logic [7:0]  rsp_balance;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: account table and session as plain integers.
    int mbal [4];
    int mfail[4];
    bit mlock[4];
    bit msess;
    int macct;

    always #5 clk = ~clk;

    atm_account_server #(
        .NUM_ACCTS    (4),
        .ACCT_W       (2),
        .INIT_BALANCE (8'd100),
        .PIN_BASE     (16'h1234),
        .MAX_TRIES    (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_acct     (req_acct),
        .req_dst_acct (req_dst_acct),
        .req_pin      (req_pin),
        .req_amount   (req_amount),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_status   (rsp_status),
        .rsp_balance  (rsp_balance)
    );

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mbal[i]  = 100;
            mfail[i] = 0;
            mlock[i] = 0;
        end
        msess = 0;
        macct = 0;
    endtask

    task automatic model_apply(input int op, input int a, input int d,
                               input logic [15:0] pin, input int amt,
                               output int st, output int bal);
        st = 0;
        if (op == 5) begin
            if (mlock[a]) st = 2;
            else if (pin == (16'h1234 ^ 16'(a))) begin
                mfail[a] = 0;
                msess = 1;
                macct = a;
            end else begin
                st = 1;
                mfail[a] = mfail[a] + 1;
                if (mfail[a] >= 3) mlock[a] = 1;
                msess = 0;
            end
        end else if (op == 4) begin
            msess = 0;
        end else if (op > 5) begin
            st = 6;
        end else if (!msess) begin
            st = 5;
        end else if (op == 0) begin
            if (mbal[macct] + amt > 255) st = 4;
            else mbal[macct] = mbal[macct] + amt;
        end else if (op == 1) begin
            if (amt > mbal[macct]) st = 3;
            else mbal[macct] = mbal[macct] - amt;
        end else if (op == 3) begin
            if (amt > mbal[macct]) st = 3;
            else if (d != macct) begin
                if (mbal[d] + amt > 255) st = 4;
                else begin
                    mbal[macct] = mbal[macct] - amt;
                    mbal[d] = mbal[d] + amt;
                end
            end
        end
        bal = msess ? mbal[macct] : 0;
    endtask

    // One full transaction: accept at edge T, idle EXEC at T+1, response
    // from T+2, optional backpressure, then handshake.
    task automatic run_txn(input int op, input int a, input int d,
                           input logic [15:0] pin, input int amt,
                           input int want_st, input int want_bal,
                           input int hold, input string name);
        int est, ebal, n;
        logic [2:0] st_seen;
        logic [7:0] bal_seen;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready_timeout req_ready=%b required=1", name, req_ready);
            return;
        end
        req_valid = 1'b1;
        req_op = 3'(op);
        req_acct = 2'(a);
        req_dst_acct = 2'(d);
        req_pin = pin;
        req_amount = 8'(amt);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = 3'($urandom);
        req_acct = 2'($urandom);
        req_dst_acct = 2'($urandom);
        req_pin = 16'($urandom);
        req_amount = 8'($urandom);
        model_apply(op, a, d, pin, amt, est, ebal);
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s exec_cycle rsp_valid=%b req_ready=%b required 0/0", name, rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s latency rsp_valid=%b required=1", name, rsp_valid);
        end
        vectors++;
        if (rsp_status !== 3'(est)) begin
            miscompares++;
            $display("FAIL %s status got=%0d required=%0d", name, rsp_status, est);
        end
        vectors++;
        if (rsp_balance !== 8'(ebal)) begin
            miscompares++;
            $display("FAIL %s balance got=%0d required=%0d", name, rsp_balance, ebal);
        end
        if (want_st >= 0) begin
            vectors++;
            if (rsp_status !== 3'(want_st)) begin
                miscompares++;
                $display("FAIL %s plan_status got=%0d required=%0d", name, rsp_status, want_st);
            end
            vectors++;
            if (rsp_balance !== 8'(want_bal)) begin
                miscompares++;
                $display("FAIL %s plan_balance got=%0d required=%0d", name, rsp_balance, want_bal);
            end
        end
        st_seen = rsp_status;
        bal_seen = rsp_balance;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_status !== st_seen ||
                rsp_balance !== bal_seen || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s hold%0d valid=%b status=%0d bal=%0d ready=%b required 1/%0d/%0d/0",
                         name, h, rsp_valid, rsp_status, rsp_balance, req_ready, st_seen, bal_seen);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s handshake rsp_valid=%b req_ready=%b required 0/1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_op = '0;
        req_acct = '0;
        req_dst_acct = '0;
        req_pin = '0;
        req_amount = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 ||
            rsp_status !== 3'd0 || rsp_balance !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_values ready=%b valid=%b status=%0d bal=%0d required 0/0/0/0",
                     req_ready, rsp_valid, rsp_status, rsp_balance);
        end
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_auth_balance();
        run_txn(5, 2, 0, 16'h1236, 0, 0, 100, 0, "auth2");
        run_txn(2, 0, 0, 16'h0000, 0, 0, 100, 0, "balance2");
    endtask

    task automatic test_deposit_withdraw();
        run_txn(0, 0, 0, 16'h0, 50,  0, 150, 0, "deposit50");
        run_txn(0, 0, 0, 16'h0, 200, 4, 150, 0, "deposit_overflow");
        run_txn(1, 0, 0, 16'h0, 151, 3, 150, 0, "withdraw_insufficient");
        run_txn(1, 0, 0, 16'h0, 150, 0, 0,   0, "withdraw_all");
        run_txn(1, 0, 0, 16'h0, 0,   0, 0,   0, "withdraw_zero");
    endtask

    task automatic test_transfer();
        run_txn(5, 1, 0, 16'h1235, 0,  0, 100, 0, "auth1");
        run_txn(3, 0, 3, 16'h0,    30, 0, 70,  0, "transfer30");
        run_txn(5, 3, 0, 16'h1237, 0,  0, 130, 0, "auth3");
        run_txn(3, 0, 3, 16'h0,    10, 0, 130, 0, "transfer_self");
        run_txn(3, 0, 1, 16'h0,   131, 3, 130, 0, "transfer_insufficient");
    endtask

    task automatic test_lockout();
        run_txn(5, 0, 0, 16'h0000, 0, 1, 0, 0, "badpin1");
        run_txn(5, 0, 0, 16'h0000, 0, 1, 0, 0, "badpin2");
        run_txn(5, 0, 0, 16'h0000, 0, 1, 0, 0, "badpin3");
        run_txn(5, 0, 0, 16'h1234, 0, 2, 0, 0, "locked");
        run_txn(1, 0, 0, 16'h0,   10, 5, 0, 0, "not_auth");
    endtask

    task automatic test_backpressure();
        run_txn(5, 2, 0, 16'h1236, 0, 0, 0, 5, "auth2_hold");
        run_txn(4, 0, 0, 16'h0,    0, 0, 0, 0, "exit");
        run_txn(2, 0, 0, 16'h0,    0, 5, 0, 0, "balance_after_exit");
    endtask

    task automatic test_reset_midflight();
        int n;
        run_txn(5, 2, 0, 16'h1236, 0, 0, 0, 0, "auth2_pre_reset");
        run_txn(0, 0, 0, 16'h0,   70, 0, 70, 0, "deposit70_pre_reset");
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b1;
        req_op = 3'd0;
        req_amount = 8'd20;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 ||
            rsp_status !== 3'd0 || rsp_balance !== 8'd0) begin
            miscompares++;
            $display("FAIL midflight_reset valid=%b ready=%b status=%0d bal=%0d required 0/0/0/0",
                     rsp_valid, req_ready, rsp_status, rsp_balance);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL dropped_response cycle%0d rsp_valid=%b required=0", i, rsp_valid);
            end
        end
        run_txn(2, 0, 0, 16'h0,    0, 5, 0,   0, "no_session_after_reset");
        run_txn(5, 2, 0, 16'h1236, 0, 0, 100, 0, "auth2_after_reset");
    endtask

    task automatic test_bad_op();
        run_txn(7, 0, 0, 16'h0, 0, 6, 100, 0, "bad_op7");
        run_txn(6, 0, 0, 16'h0, 0, 6, 100, 0, "bad_op6");
    endtask

    task automatic test_random();
        int op, a, d, amt;
        logic [15:0] pin;
        for (int k = 0; k < 200; k++) begin
            op  = int'($urandom_range(0, 7));
            a   = int'($urandom_range(0, 3));
            d   = int'($urandom_range(0, 3));
            amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                               : int'($urandom_range(0, 60));
            pin = ($urandom_range(0, 9) < 8) ? (16'h1234 ^ 16'(a)) : 16'($urandom);
            run_txn(op, a, d, pin, amt, -1, 0, int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_auth_balance();
        test_deposit_withdraw();
        test_transfer();
        test_lockout();
        test_backpressure();
        test_reset_midflight();
        test_bad_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
